// File: rtl/stage4ma_if.sv
// Data-memory bus of the diad memory-access stage: one request/acknowledge channel.
// The stage drives the master side; data memory (or a bench model) drives the slave side.

interface stage4ma_if;
    // req rises with addr/we/wdata valid and holds them stable until a cycle
    // with ack=1; that cycle completes the transfer, and rdata is sampled then.
    logic        req;
    logic        we;
    logic [23:0] addr;
    logic [23:0] wdata;
    logic [23:0] rdata;
    logic        ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/stage4ma.sv
// diad memory-access stage: passes ALU results through or runs one LD/ST on the memory bus.
// Optional REQ timeout with sticky fault_out is enabled by defining DIAD_MA_TIMEOUT_EN.

`ifndef OPC_R_LD
`define OPC_R_LD  8'h10
`endif
`ifndef OPC_R_ST
`define OPC_R_ST  8'h11
`endif
`ifndef OPC_I_LDi
`define OPC_I_LDi 8'h50
`endif
`ifndef OPC_I_STi
`define OPC_I_STi 8'h51
`endif
`ifndef OPC_S_HLT
`define OPC_S_HLT 8'hFF
`endif

module stage4ma #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_in,
    input  logic [23:0] pc_in,
    input  logic [23:0] instr_in,
    input  logic [3:0]  tgt_gp_in,
    input  logic [3:0]  tgt_sr_in,
    input  logic [23:0] result_in,
    input  logic [23:0] store_data_in,
    input  logic [3:0]  flags_in,
    input  logic        branch_taken_in,
    stage4ma_if.master  mem,
    output logic        stall_out,
    output logic        enable_out,
    output logic [23:0] pc_out,
    output logic [23:0] instr_out,
    output logic [3:0]  tgt_gp_out,
    output logic [3:0]  tgt_sr_out,
    output logic [23:0] result_out,
    output logic [3:0]  flags_out,
    output logic        branch_taken_out,
    output logic        fault_out,
    output logic        dbg_state
);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t      state;
    logic [23:0] h_pc;
    logic [23:0] h_instr;
    logic [3:0]  h_gp;
    logic [3:0]  h_sr;
    logic [23:0] h_result;
    logic [23:0] h_wdata;
    logic [3:0]  h_flags;
    logic        h_br;
    logic        h_store;

    logic [7:0]  opcode;
    logic        is_load;
    logic        is_store;
    logic        to_hit;

    assign opcode   = instr_in[23:16];
    assign is_load  = (opcode == `OPC_R_LD) || (opcode == `OPC_I_LDi);
    assign is_store = (opcode == `OPC_R_ST) || (opcode == `OPC_I_STi);

    // Bus outputs are decoded from state so an async reset drops them at once.
    assign stall_out = (state == REQ);
    assign dbg_state = state;
    assign mem.req   = (state == REQ);
    assign mem.we    = (state == REQ) && h_store;
    assign mem.addr  = (state == REQ) ? h_result : 24'h0;
    assign mem.wdata = (state == REQ) ? h_wdata  : 24'h0;

`ifdef DIAD_MA_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] to_cnt;
    logic       fault_q;

    assign to_hit    = (state == REQ) && (to_cnt == TO_LAST);
    assign fault_out = fault_q;

    // Counter sits at zero in IDLE, so every REQ entry starts a fresh count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt  <= 8'h0;
            fault_q <= 1'b0;
        end else if (state == IDLE) begin
            to_cnt <= 8'h0;
        end else if (!mem.ack) begin
            if (to_hit) fault_q <= 1'b1;
            else        to_cnt  <= to_cnt + 8'd1;
        end
    end
`else
    logic [7:0] timeout_unused;
    assign timeout_unused = 8'(TIMEOUT_CYCLES);
    assign to_hit         = 1'b0;
    assign fault_out      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            h_pc             <= 24'h0;
            h_instr          <= 24'h0;
            h_gp             <= 4'h0;
            h_sr             <= 4'h0;
            h_result         <= 24'h0;
            h_wdata          <= 24'h0;
            h_flags          <= 4'h0;
            h_br             <= 1'b0;
            h_store          <= 1'b0;
            enable_out       <= 1'b0;
            pc_out           <= 24'h0;
            instr_out        <= 24'h0;
            tgt_gp_out       <= 4'h0;
            tgt_sr_out       <= 4'h0;
            result_out       <= 24'h0;
            flags_out        <= 4'h0;
            branch_taken_out <= 1'b0;
        end else begin
            enable_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable_in) begin
                        if (is_load || is_store) begin
                            h_pc     <= pc_in;
                            h_instr  <= instr_in;
                            h_gp     <= tgt_gp_in;
                            h_sr     <= tgt_sr_in;
                            h_result <= result_in;
                            h_wdata  <= is_store ? store_data_in : 24'h0;
                            h_flags  <= flags_in;
                            h_br     <= branch_taken_in;
                            h_store  <= is_store;
                            state    <= REQ;
                        end else begin
                            enable_out       <= 1'b1;
                            pc_out           <= pc_in;
                            instr_out        <= instr_in;
                            tgt_gp_out       <= tgt_gp_in;
                            tgt_sr_out       <= tgt_sr_in;
                            result_out       <= result_in;
                            flags_out        <= flags_in;
                            branch_taken_out <= branch_taken_in;
                        end
                    end
                end
                REQ: begin
                    // A timeout retires the held instruction with a zero result.
                    if (mem.ack || to_hit) begin
                        state            <= IDLE;
                        enable_out       <= 1'b1;
                        pc_out           <= h_pc;
                        instr_out        <= h_instr;
                        tgt_gp_out       <= h_gp;
                        tgt_sr_out       <= h_sr;
                        flags_out        <= h_flags;
                        branch_taken_out <= h_br;
                        if (mem.ack) result_out <= h_store ? h_result : mem.rdata;
                        else         result_out <= 24'h0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage4ma.sv
// Directed bench for stage4ma: table of pass-through vectors plus hand-written memory sequences.
// Every retire is also checked against an expected-result queue.

`ifndef OPC_R_LD
`define OPC_R_LD  8'h10
`endif
`ifndef OPC_R_ST
`define OPC_R_ST  8'h11
`endif
`ifndef OPC_I_LDi
`define OPC_I_LDi 8'h50
`endif
`ifndef OPC_I_STi
`define OPC_I_STi 8'h51
`endif
`ifndef OPC_S_HLT
`define OPC_S_HLT 8'hFF
`endif

module tb_stage4ma;

`ifdef DIAD_MA_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_in;
    logic [23:0] pc_in;
    logic [23:0] instr_in;
    logic [3:0]  tgt_gp_in;
    logic [3:0]  tgt_sr_in;
    logic [23:0] result_in;
    logic [23:0] store_data_in;
    logic [3:0]  flags_in;
    logic        branch_taken_in;
    logic        stall_out;
    logic        enable_out;
    logic [23:0] pc_out;
    logic [23:0] instr_out;
    logic [3:0]  tgt_gp_out;
    logic [3:0]  tgt_sr_out;
    logic [23:0] result_out;
    logic [3:0]  flags_out;
    logic        branch_taken_out;
    logic        fault_out;
    logic        dbg_state;

    stage4ma_if mem ();

    stage4ma #(.TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .enable_in        (enable_in),
        .pc_in            (pc_in),
        .instr_in         (instr_in),
        .tgt_gp_in        (tgt_gp_in),
        .tgt_sr_in        (tgt_sr_in),
        .result_in        (result_in),
        .store_data_in    (store_data_in),
        .flags_in         (flags_in),
        .branch_taken_in  (branch_taken_in),
        .mem              (mem),
        .stall_out        (stall_out),
        .enable_out       (enable_out),
        .pc_out           (pc_out),
        .instr_out        (instr_out),
        .tgt_gp_out       (tgt_gp_out),
        .tgt_sr_out       (tgt_sr_out),
        .result_out       (result_out),
        .flags_out        (flags_out),
        .branch_taken_out (branch_taken_out),
        .fault_out        (fault_out),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad   = 0;
    logic [23:0] exp_q[$];
    logic [23:0] mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (enable_out === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL retire: unexpected retire with result %0h", result_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (result_out !== mon_exp) begin
                    bad++;
                    $display("FAIL retire_result: got %0h expected %0h", result_out, mon_exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic en, input logic [23:0] pc, input logic [23:0] instr,
                         input logic [3:0] gp, input logic [3:0] sr, input logic [23:0] res,
                         input logic [23:0] sd, input logic [3:0] fl, input logic br);
        enable_in       = en;
        pc_in           = pc;
        instr_in        = instr;
        tgt_gp_in       = gp;
        tgt_sr_in       = sr;
        result_in       = res;
        store_data_in   = sd;
        flags_in        = fl;
        branch_taken_in = br;
    endtask

    task automatic chk_bus(input string tag, input logic req, input logic we,
                           input logic [23:0] addr, input logic [23:0] wdata);
        chk({tag, "_req"},   mem.req,   req);
        chk({tag, "_we"},    mem.we,    we);
        chk({tag, "_addr"},  mem.addr,  addr);
        chk({tag, "_wdata"}, mem.wdata, wdata);
        chk({tag, "_stall"}, stall_out, req);
        chk({tag, "_dbg"},   dbg_state, req);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        en;
        logic [23:0] pc;
        logic [23:0] instr;
        logic [3:0]  gp;
        logic [3:0]  sr;
        logic [23:0] res;
        logic [3:0]  fl;
        logic        br;
        logic        x_en;
        logic [23:0] x_pc;
        logic [23:0] x_instr;
        logic [23:0] x_res;
        logic [3:0]  x_fl;
        logic        x_br;
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{1'b1, 24'h000100, 24'h013400, 4'h3, 4'h0, 24'h000123, 4'h1, 1'b0,
                  1'b1, 24'h000100, 24'h013400, 24'h000123, 4'h1, 1'b0};
        vt[1] = '{1'b0, 24'h000200, 24'h020000, 4'h5, 4'h5, 24'hFFFFFF, 4'hF, 1'b1,
                  1'b0, 24'h000100, 24'h013400, 24'h000123, 4'h1, 1'b0};
        vt[2] = '{1'b1, 24'h000104, 24'h20ABCD, 4'h7, 4'h2, 24'hFFFFFF, 4'hA, 1'b1,
                  1'b1, 24'h000104, 24'h20ABCD, 24'hFFFFFF, 4'hA, 1'b1};
        vt[3] = '{1'b1, 24'h000108, 24'hFF0000, 4'h0, 4'h0, 24'h000000, 4'h0, 1'b0,
                  1'b1, 24'h000108, 24'hFF0000, 24'h000000, 4'h0, 1'b0};
        vt[4] = '{1'b0, 24'h00010C, 24'h100000, 4'h1, 4'h1, 24'h000040, 4'h3, 1'b1,
                  1'b0, 24'h000108, 24'hFF0000, 24'h000000, 4'h0, 1'b0};
        vt[5] = '{1'b1, 24'h000110, 24'h305555, 4'h9, 4'h4, 24'h00ABCD, 4'h5, 1'b1,
                  1'b1, 24'h000110, 24'h305555, 24'h00ABCD, 4'h5, 1'b1};

        rst       = 1'b1;
        mem.ack   = 1'b0;
        mem.rdata = 24'h0;
        drive(1'b0, 24'h0, 24'h0, 4'h0, 4'h0, 24'h0, 24'h0, 4'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_enable_out", enable_out, 0);
        chk("rst_result_out", result_out, 0);
        chk("rst_pc_out",     pc_out,     0);
        chk("rst_fault_out",  fault_out,  0);
        chk_bus("rst", 1'b0, 1'b0, 24'h0, 24'h0);
        rst = 1'b0;

        // Pass-through and idle-hold vectors.
        for (int i = 0; i < 6; i++) begin
            drive(vt[i].en, vt[i].pc, vt[i].instr, vt[i].gp, vt[i].sr, vt[i].res,
                  24'h777777, vt[i].fl, vt[i].br);
            if (vt[i].x_en) exp_q.push_back(vt[i].x_res);
            @(negedge clk);
            chk($sformatf("vec%0d_enable", i), enable_out,       vt[i].x_en);
            chk($sformatf("vec%0d_pc", i),     pc_out,           vt[i].x_pc);
            chk($sformatf("vec%0d_instr", i),  instr_out,        vt[i].x_instr);
            chk($sformatf("vec%0d_result", i), result_out,       vt[i].x_res);
            chk($sformatf("vec%0d_flags", i),  flags_out,        vt[i].x_fl);
            chk($sformatf("vec%0d_branch", i), branch_taken_out, vt[i].x_br);
            chk($sformatf("vec%0d_req", i),    mem.req,          0);
        end

        // LD, zero-wait ack.
        drive(1'b1, 24'h000200, {`OPC_R_LD, 16'h0011}, 4'h6, 4'h2, 24'h000040,
              24'h999999, 4'h2, 1'b1);
        exp_q.push_back(24'hABCDEF);
        @(negedge clk);
        chk_bus("ld0", 1'b1, 1'b0, 24'h000040, 24'h0);
        chk("ld0_enable_in_req", enable_out, 0);
        enable_in = 1'b0;
        mem.ack   = 1'b1;
        mem.rdata = 24'hABCDEF;
        @(negedge clk);
        mem.ack   = 1'b0;
        chk_bus("ld0_done", 1'b0, 1'b0, 24'h0, 24'h0);
        chk("ld0_enable",  enable_out,       1);
        chk("ld0_result",  result_out,       24'hABCDEF);
        chk("ld0_pc",      pc_out,           24'h000200);
        chk("ld0_gp",      tgt_gp_out,       4'h6);
        chk("ld0_sr",      tgt_sr_out,       4'h2);
        chk("ld0_flags",   flags_out,        4'h2);
        chk("ld0_branch",  branch_taken_out, 1);

        // ST, three wait cycles, then a stray ack in IDLE.
        drive(1'b1, 24'h000204, {`OPC_R_ST, 16'h0022}, 4'h0, 4'h0, 24'h000010,
              24'h5A5A5A, 4'h8, 1'b0);
        exp_q.push_back(24'h000010);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            enable_in = 1'b0;
            chk_bus($sformatf("st_c%0d", c), 1'b1, 1'b1, 24'h000010, 24'h5A5A5A);
            chk($sformatf("st_c%0d_enable", c), enable_out, 0);
            if (c == 4) mem.ack = 1'b1;
        end
        @(negedge clk);
        mem.ack = 1'b0;
        chk_bus("st_done", 1'b0, 1'b0, 24'h0, 24'h0);
        chk("st_enable", enable_out, 1);
        chk("st_result", result_out, 24'h000010);
        chk("st_flags",  flags_out,  4'h8);
        @(negedge clk);
        chk("st_pulse_once", enable_out, 0);
        mem.ack   = 1'b1;
        mem.rdata = 24'h111111;
        @(negedge clk);
        mem.ack = 1'b0;
        chk("idle_ack_enable", enable_out, 0);
        chk("idle_ack_stall",  stall_out,  0);
        chk("idle_ack_result", result_out, 24'h000010);

        // LDi then ADD with upstream holding enable_in through the stall.
        drive(1'b1, 24'h000300, {`OPC_I_LDi, 16'h0033}, 4'h1, 4'h0, 24'h000080,
              24'h0, 4'h0, 1'b0);
        exp_q.push_back(24'h123456);
        @(negedge clk);
        chk("b2b_stall1", stall_out, 1);
        @(negedge clk);
        chk("b2b_stall2", stall_out, 1);
        mem.ack   = 1'b1;
        mem.rdata = 24'h123456;
        @(negedge clk);
        mem.ack = 1'b0;
        chk("b2b_ld_retire", enable_out, 1);
        chk("b2b_ld_pc",     pc_out,     24'h000300);
        chk("b2b_stall3",    stall_out,  0);
        drive(1'b1, 24'h000303, 24'h013300, 4'h2, 4'h0, 24'h000777, 24'h0, 4'h4, 1'b0);
        exp_q.push_back(24'h000777);
        @(negedge clk);
        enable_in = 1'b0;
        chk("b2b_add_retire", enable_out, 1);
        chk("b2b_add_pc",     pc_out,     24'h000303);
        chk("b2b_add_flags",  flags_out,  4'h4);
        @(negedge clk);
        chk("b2b_add_once", enable_out, 0);

        // Reset in the second REQ cycle of a load.
        drive(1'b1, 24'h000400, {`OPC_I_LDi, 16'h0044}, 4'h3, 4'h0, 24'h000099,
              24'h0, 4'h0, 1'b0);
        @(negedge clk);
        enable_in = 1'b0;
        @(negedge clk);
        chk("rstm_req_before", mem.req, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstm_req_async",    mem.req,    0);
        chk("rstm_stall_async",  stall_out,  0);
        chk("rstm_enable_async", enable_out, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) mem.ack = 1'b1;
            @(negedge clk);
            chk($sformatf("rstm_idle%0d_enable", c), enable_out, 0);
            chk($sformatf("rstm_idle%0d_stall", c),  stall_out,  0);
        end
        mem.ack = 1'b0;
        chk("rstm_pc_cleared",     pc_out,     0);
        chk("rstm_result_cleared", result_out, 0);

`ifdef DIAD_MA_TIMEOUT_EN
        drive(1'b1, 24'h000500, {`OPC_R_LD, 16'h0055}, 4'h5, 4'h0, 24'h000123,
              24'h0, 4'h0, 1'b0);
        exp_q.push_back(24'h000000);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            enable_in = 1'b0;
            chk($sformatf("to_c%0d_req", c), mem.req, 1);
        end
        @(negedge clk);
        chk("to_req_dropped", mem.req,    0);
        chk("to_enable",      enable_out, 1);
        chk("to_result",      result_out, 0);
        chk("to_fault",       fault_out,  1);
        @(negedge clk);
        chk("to_fault_sticky", fault_out,  1);
        chk("to_pulse_once",   enable_out, 0);
`else
        chk("fault_tied_low", fault_out, 0);
`endif

        @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
